rs_station: RTL and testbench
=============================

# rs_station

Parametrised reservation station for the out-of-order core. It sits between the decoder/dispatch stage and the ALU. It buffers up to DEPTH instructions whose operands may still be pending. It snoops NUM_CDB result broadcast channels to capture operand values, and issues the oldest fully-ready entry to the ALU over a valid/ready handshake.

## Interface
- DEPTH, 8: number of entries (≥2).
- TAG_W, 4: ROB index width (operand tags and destination tag).
- OP_W, 6: internal op-code width.
- NUM_CDB, 2: number of broadcast channels snooped.
- clk_in, in, 1: the single clock.
- rst_in, in, 1: reset, asynchronous and active-high.
- rdy_in, in, 1: global enable. Low freezes all state.
- flush_in, in, 1: misprediction flush. Discards all entries.
- disp_valid, in, 1: dispatch request.
- disp_ready, out, 1: a free entry exists.
- disp_op, in, OP_W: op-code.
- disp_rs1_rdy / disp_rs2_rdy, in, 1 each: operand value already valid.
- disp_rs1_val / disp_rs2_val, in, 32 each: operand values.
- disp_rs1_tag / disp_rs2_tag, in, TAG_W each: producer ROB tag when the operand is not ready.
- disp_imm, in, 32: immediate.
- disp_pc, in, 32: instruction PC.
- disp_dest, in, TAG_W: destination ROB tag.
- cdb_valid, in, NUM_CDB: per-channel broadcast valid.
- cdb_tag, in, NUM_CDB*TAG_W: channel c occupies bits [c*TAG_W +: TAG_W].
- cdb_value, in, NUM_CDB*32: channel c occupies bits [c*32 +: 32].
- iss_valid, out, 1: an issued instruction is presented.
- iss_ready, in, 1: the ALU accepts it.
- iss_op, iss_vj, iss_vk, iss_imm, iss_pc, iss_dest, out: payload of the selected entry.
- count, out, $clog2(DEPTH+1): occupied entries.

## Operation
- Entry state: valid, op, two operands (rdy, val, tag), imm, pc, dest. Age is tracked in a DEPTH×DEPTH age matrix: row i, bit j is set when entry i is older than entry j.
- **Dispatch fire** = disp_valid & disp_ready & rdy_in & !flush_in.
  - Allocates the lowest-index free entry.
  - Sets that entry's age row to all current valid entries' complement (it is younger than every valid entry), and sets its column bit in every valid row.
- **Dispatch bypass:** if a not-ready dispatched operand's tag matches any cdb_valid channel in the same cycle, the entry stores that channel's value with rdy=1.
- **Wakeup:** each cycle with rdy_in high, every valid entry with an unready operand whose tag matches a valid channel captures the value and sets rdy.
  - When several channels match the same tag, the lowest channel index wins.
- **Selection:** an entry is a candidate when it is valid and both rdy bits are set. The selected entry is the candidate with no older candidate.
  - iss_valid = any candidate exists. The payload is the selected entry's fields.
  - This is combinational from registered state, so a same-cycle CDB match does not make an entry issuable.
- **Issue fire** = iss_valid & iss_ready & rdy_in & !flush_in. It clears the selected entry's valid bit at the edge.
- disp_ready = (count != DEPTH). A slot freed by issue is not reusable in the same cycle.
- count: +1 on dispatch fire, −1 on issue fire, unchanged when both occur.
- **Flush** (flush_in & rdy_in): clears all valid bits and count. It has priority over dispatch, issue and wakeup in that cycle.
- **rdy_in low:** no state changes. Outputs keep reflecting the frozen state, and iss_valid may stay high.

## Timing
- Reset values: all valid bits 0, age matrix 0, count 0, disp_ready 1, iss_valid 0. The payload outputs are 0 because the array is cleared on reset.
- Reset asserted mid-operation empties the station immediately and asynchronously.
- Latency:
  - An entry dispatched with both operands ready at edge N presents iss_valid in cycle N+1.
  - An operand woken at edge N makes the entry issuable from cycle N+1.
- Each operand is 32-bit; values are copied and never modified. The tag compare is an exact TAG_W match.
- Holding iss_ready low stalls issue indefinitely. The selection can change while stalled if an older entry becomes ready, so the ALU samples the payload only on fire.

## Structure
- Shared package/header holds TAG_W, OP_W, the op-code constants and the CDB channel packing macros. These are common with the ROB and the ALU.
- One sub-module, rs_age_select: it takes a DEPTH candidate vector and the age matrix and returns a one-hot grant plus the index. The entry array, wakeup and allocation stay in rs_station.

## Test plan
- **Ready dispatch:** dispatch addi (rs1 ready, val=5, imm=3, dest=2) → iss_valid next cycle with iss_vj=5, iss_imm=3, iss_dest=2. count goes 1→0 after the fire.
- **Wakeup:** dispatch with rs1 tag=7 not ready, then broadcast channel 1 with tag=7, value=0x1234 → iss_valid one cycle after the broadcast edge, with iss_vj=0x1234.
- **Dispatch bypass:** dispatch with rs2 tag=3 in the same cycle as channel 0 broadcasting tag=3, value=9 → iss_vk=9 and the entry is issuable next cycle.
- **Age order:** dispatch A(tag 4 pending), B(ready), C(ready), then wake A → with iss_ready=1, issue order is B, C, A. After A wakes while C is still present, the older of the two ready entries issues first.
- **Full:** fill DEPTH=8 entries with pending operands → disp_ready=0 and count=8. Further disp_valid is ignored. A simultaneous issue and dispatch leaves count unchanged.
- **Flush and reset:** with 5 entries, assert flush_in together with disp_valid → count=0, iss_valid=0 and no allocation. Asserting rst_in asynchronously mid-stream → all outputs return to their reset values without a clock edge.

Source files
------------

// File: rtl/rs_station_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rs_station_pkg
// Brief   : Widths, op-codes and CDB layout shared by the ROB, RS and ALU.
// Rev     : 1.0
// ============================================================================
package rs_station_pkg;

    localparam int RS_TAG_W   = 4;
    localparam int RS_OP_W    = 6;
    localparam int RS_NUM_CDB = 2;
    localparam int XLEN       = 32;

    typedef enum logic [RS_OP_W-1:0] {
        OP_ADD  = 6'd0,
        OP_ADDI = 6'd1,
        OP_SUB  = 6'd2,
        OP_AND  = 6'd3,
        OP_OR   = 6'd4,
        OP_XOR  = 6'd5
    } rs_op_e;

endpackage
`default_nettype wire

// File: rtl/rs_age_select.sv
`default_nettype none
// ============================================================================
// Module  : rs_age_select
// Brief   : Picks the candidate that has no older candidate (age-matrix pick).
// Rev     : 1.0
// ============================================================================
module rs_age_select #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]       i_cand,
    input  logic [DEPTH*DEPTH-1:0] i_age,
    output logic [DEPTH-1:0]       o_grant,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_any
);

    // Row j, bit i of the matrix says entry j is older than entry i.
    for (genvar i = 0; i < DEPTH; i++) begin : g_row
        logic [DEPTH-1:0] w_older;
        for (genvar j = 0; j < DEPTH; j++) begin : g_col
            if (j == i) begin : g_self
                assign w_older[j] = 1'b0;
            end else begin : g_other
                assign w_older[j] = i_age[j*DEPTH + i];
            end
        end
        assign o_grant[i] = i_cand[i] & ~|(w_older & i_cand);
    end

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (o_grant[i]) o_idx = o_idx | IDX_W'(i);
        end
    end

    assign o_any = |i_cand;

endmodule
`default_nettype wire

// File: rtl/rs_station.sv
`default_nettype none
// ============================================================================
// Module  : rs_station
// Brief   : Reservation station; buffers ops, snoops the CDB, issues oldest ready.
// Rev     : 1.0
// ============================================================================
module rs_station
    import rs_station_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TAG_W   = RS_TAG_W,
    parameter int OP_W    = RS_OP_W,
    parameter int NUM_CDB = RS_NUM_CDB
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        flush_in,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [OP_W-1:0]             disp_op,
    input  logic                        disp_rs1_rdy,
    input  logic                        disp_rs2_rdy,
    input  logic [XLEN-1:0]             disp_rs1_val,
    input  logic [XLEN-1:0]             disp_rs2_val,
    input  logic [TAG_W-1:0]            disp_rs1_tag,
    input  logic [TAG_W-1:0]            disp_rs2_tag,
    input  logic [XLEN-1:0]             disp_imm,
    input  logic [XLEN-1:0]             disp_pc,
    input  logic [TAG_W-1:0]            disp_dest,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]     cdb_value,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output logic [OP_W-1:0]             iss_op,
    output logic [XLEN-1:0]             iss_vj,
    output logic [XLEN-1:0]             iss_vk,
    output logic [XLEN-1:0]             iss_imm,
    output logic [XLEN-1:0]             iss_pc,
    output logic [TAG_W-1:0]            iss_dest,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
    logic [OP_W-1:0]  op_q [DEPTH];
    logic [OP_W-1:0]  op_d [DEPTH];
    logic [XLEN-1:0]  rs1_val_q [DEPTH];
    logic [XLEN-1:0]  rs1_val_d [DEPTH];
    logic [XLEN-1:0]  rs2_val_q [DEPTH];
    logic [XLEN-1:0]  rs2_val_d [DEPTH];
    logic [TAG_W-1:0] rs1_tag_q [DEPTH];
    logic [TAG_W-1:0] rs1_tag_d [DEPTH];
    logic [TAG_W-1:0] rs2_tag_q [DEPTH];
    logic [TAG_W-1:0] rs2_tag_d [DEPTH];
    logic [XLEN-1:0]  imm_q [DEPTH];
    logic [XLEN-1:0]  imm_d [DEPTH];
    logic [XLEN-1:0]  pc_q [DEPTH];
    logic [XLEN-1:0]  pc_d [DEPTH];
    logic [TAG_W-1:0] dest_q [DEPTH];
    logic [TAG_W-1:0] dest_d [DEPTH];
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH*DEPTH-1:0] w_age_flat;
    logic [DEPTH-1:0]       w_grant;
    logic [IDX_W-1:0]       w_sel_idx;
    logic [IDX_W-1:0]       w_alloc_idx;
    logic                   w_disp_fire;
    logic                   w_iss_fire;
    logic [XLEN:0]          w_lk1, w_lk2;

    // Returns {hit, value}; scanning downward lets the lowest channel win.
    function automatic logic [XLEN:0] cdb_lookup(input logic [TAG_W-1:0] tag);
        logic [XLEN:0] res;
        res = '0;
        for (int c = NUM_CDB-1; c >= 0; c--) begin
            if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == tag))
                res = {1'b1, cdb_value[c*XLEN +: XLEN]};
        end
        return res;
    endfunction

    for (genvar i = 0; i < DEPTH; i++) begin : g_age_flat
        assign w_age_flat[i*DEPTH +: DEPTH] = age_q[i];
    end

    rs_age_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_age_select (
        .i_cand  (valid_q & rs1_rdy_q & rs2_rdy_q),
        .i_age   (w_age_flat),
        .o_grant (w_grant),
        .o_idx   (w_sel_idx),
        .o_any   (iss_valid)
    );

    always_comb begin
        w_alloc_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!valid_q[i]) w_alloc_idx = IDX_W'(i);
        end
    end

    assign disp_ready  = (count_q != FULL_CNT);
    assign w_disp_fire = disp_valid & disp_ready & rdy_in & ~flush_in;
    assign w_iss_fire  = iss_valid & iss_ready & rdy_in & ~flush_in;

    always_comb begin
        valid_d   = valid_q;
        rs1_rdy_d = rs1_rdy_q;
        rs2_rdy_d = rs2_rdy_q;
        op_d      = op_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        rs1_tag_d = rs1_tag_q;
        rs2_tag_d = rs2_tag_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        dest_d    = dest_q;
        age_d     = age_q;
        count_d   = count_q;
        w_lk1     = '0;
        w_lk2     = '0;
        if (rdy_in) begin
            if (flush_in) begin
                valid_d = '0;
                count_d = '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    w_lk1 = cdb_lookup(rs1_tag_q[i]);
                    w_lk2 = cdb_lookup(rs2_tag_q[i]);
                    if (valid_q[i] && !rs1_rdy_q[i] && w_lk1[XLEN]) begin
                        rs1_rdy_d[i] = 1'b1;
                        rs1_val_d[i] = w_lk1[XLEN-1:0];
                    end
                    if (valid_q[i] && !rs2_rdy_q[i] && w_lk2[XLEN]) begin
                        rs2_rdy_d[i] = 1'b1;
                        rs2_val_d[i] = w_lk2[XLEN-1:0];
                    end
                end
                if (w_iss_fire) valid_d = valid_d & ~w_grant;
                if (w_disp_fire) begin
                    w_lk1 = cdb_lookup(disp_rs1_tag);
                    w_lk2 = cdb_lookup(disp_rs2_tag);
                    valid_d[w_alloc_idx]   = 1'b1;
                    op_d[w_alloc_idx]      = disp_op;
                    rs1_rdy_d[w_alloc_idx] = disp_rs1_rdy | w_lk1[XLEN];
                    rs2_rdy_d[w_alloc_idx] = disp_rs2_rdy | w_lk2[XLEN];
                    rs1_val_d[w_alloc_idx] = disp_rs1_rdy ? disp_rs1_val : w_lk1[XLEN-1:0];
                    rs2_val_d[w_alloc_idx] = disp_rs2_rdy ? disp_rs2_val : w_lk2[XLEN-1:0];
                    rs1_tag_d[w_alloc_idx] = disp_rs1_tag;
                    rs2_tag_d[w_alloc_idx] = disp_rs2_tag;
                    imm_d[w_alloc_idx]     = disp_imm;
                    pc_d[w_alloc_idx]      = disp_pc;
                    dest_d[w_alloc_idx]    = disp_dest;
                    // New entry is younger than everything currently resident.
                    for (int i = 0; i < DEPTH; i++) begin
                        if (valid_q[i]) age_d[i][w_alloc_idx] = 1'b1;
                    end
                    age_d[w_alloc_idx] = ~valid_q;
                end
                case ({w_disp_fire, w_iss_fire})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q   <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]      <= '0;
                rs1_val_q[i] <= '0;
                rs2_val_q[i] <= '0;
                rs1_tag_q[i] <= '0;
                rs2_tag_q[i] <= '0;
                imm_q[i]     <= '0;
                pc_q[i]      <= '0;
                dest_q[i]    <= '0;
                age_q[i]     <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            rs1_rdy_q <= rs1_rdy_d;
            rs2_rdy_q <= rs2_rdy_d;
            count_q   <= count_d;
            op_q      <= op_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            rs1_tag_q <= rs1_tag_d;
            rs2_tag_q <= rs2_tag_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            dest_q    <= dest_d;
            age_q     <= age_d;
        end
    end

    assign iss_op   = op_q[w_sel_idx];
    assign iss_vj   = rs1_val_q[w_sel_idx];
    assign iss_vk   = rs2_val_q[w_sel_idx];
    assign iss_imm  = imm_q[w_sel_idx];
    assign iss_pc   = pc_q[w_sel_idx];
    assign iss_dest = dest_q[w_sel_idx];
    assign count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_station.sv
`default_nettype none
// ============================================================================
// Module  : tb_rs_station
// Brief   : Directed self-checking bench for rs_station.
// Rev     : 1.0
// ============================================================================
module tb_rs_station;
    import rs_station_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic        disp_valid, disp_ready;
    logic [5:0]  disp_op;
    logic        disp_rs1_rdy, disp_rs2_rdy;
    logic [31:0] disp_rs1_val, disp_rs2_val;
    logic [3:0]  disp_rs1_tag, disp_rs2_tag;
    logic [31:0] disp_imm, disp_pc;
    logic [3:0]  disp_dest;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_value;
    logic        iss_valid, iss_ready;
    logic [5:0]  iss_op;
    logic [31:0] iss_vj, iss_vk, iss_imm, iss_pc;
    logic [3:0]  iss_dest;
    logic [3:0]  count;

    int passed = 0;
    int total  = 0;

    rs_station #(.DEPTH(8), .TAG_W(4), .OP_W(6), .NUM_CDB(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_dest(disp_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_imm(iss_imm), .iss_pc(iss_pc),
        .iss_dest(iss_dest), .count(count)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 2'b00;
        cdb_tag    = 8'h00;
        cdb_value  = 64'h0;
        iss_ready  = 1'b0;
        flush_in   = 1'b0;
    endtask

    task automatic set_disp(input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                            input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                            input logic [31:0] imm, input logic [3:0] dest);
        disp_valid   = 1'b1;
        disp_op      = OP_ADDI;
        disp_rs1_rdy = r1; disp_rs1_val = v1; disp_rs1_tag = t1;
        disp_rs2_rdy = r2; disp_rs2_val = v2; disp_rs2_tag = t2;
        disp_imm     = imm;
        disp_dest    = dest;
        disp_pc      = 32'h1000 + {26'd0, dest, 2'b00};
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; idle();
        set_disp(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        disp_valid = 1'b0;
        step(); step();
        rst_in = 1'b0;
        step();
        total++; if (count !== 4'd0)      $display("FAIL reset_count got %0d want 0", count); else passed++;
        total++; if (disp_ready !== 1'b1) $display("FAIL reset_disp_ready got %b want 1", disp_ready); else passed++;
        total++; if (iss_valid !== 1'b0)  $display("FAIL reset_iss_valid got %b want 0", iss_valid); else passed++;
        total++; if (iss_vj !== 32'h0)    $display("FAIL reset_iss_vj got %h want 0", iss_vj); else passed++;
        total++; if (iss_pc !== 32'h0)    $display("FAIL reset_iss_pc got %h want 0", iss_pc); else passed++;
    endtask

    task automatic test_ready_dispatch();
        set_disp(1'b1, 32'd5, 4'h0, 1'b1, 32'd0, 4'h0, 32'd3, 4'd2);
        step();
        disp_valid = 1'b0;
        total++; if (iss_valid !== 1'b1)      $display("FAIL rd_iss_valid got %b want 1", iss_valid); else passed++;
        total++; if (iss_vj !== 32'd5)        $display("FAIL rd_vj got %0d want 5", iss_vj); else passed++;
        total++; if (iss_imm !== 32'd3)       $display("FAIL rd_imm got %0d want 3", iss_imm); else passed++;
        total++; if (iss_dest !== 4'd2)       $display("FAIL rd_dest got %0d want 2", iss_dest); else passed++;
        total++; if (iss_op !== 6'd1)         $display("FAIL rd_op got %0d want 1", iss_op); else passed++;
        total++; if (iss_pc !== 32'h1008)     $display("FAIL rd_pc got %h want 1008", iss_pc); else passed++;
        total++; if (count !== 4'd1)          $display("FAIL rd_count1 got %0d want 1", count); else passed++;
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;
        total++; if (count !== 4'd0)          $display("FAIL rd_count0 got %0d want 0", count); else passed++;
        total++; if (iss_valid !== 1'b0)      $display("FAIL rd_after_issue got %b want 0", iss_valid); else passed++;
    endtask

    task automatic test_wakeup();
        set_disp(1'b0, 32'h0, 4'd7, 1'b1, 32'd11, 4'h0, 32'd0, 4'd5);
        step();
        disp_valid = 1'b0;
        total++; if (iss_valid !== 1'b0) $display("FAIL wk_pending got %b want 0", iss_valid); else passed++;
        cdb_valid = 2'b11;
        cdb_tag   = {4'd7, 4'd6};
        cdb_value = {32'h0000_1234, 32'hDEAD_BEEF};
        #1;
        total++; if (iss_valid !== 1'b0) $display("FAIL wk_same_cycle got %b want 0", iss_valid); else passed++;
        step();
        idle();
        total++; if (iss_valid !== 1'b1)   $display("FAIL wk_iss_valid got %b want 1", iss_valid); else passed++;
        total++; if (iss_vj !== 32'h1234)  $display("FAIL wk_vj got %h want 1234", iss_vj); else passed++;
        total++; if (iss_vk !== 32'd11)    $display("FAIL wk_vk got %0d want 11", iss_vk); else passed++;
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;
        total++; if (count !== 4'd0) $display("FAIL wk_count got %0d want 0", count); else passed++;
    endtask

    task automatic test_bypass();
        set_disp(1'b1, 32'd1, 4'h0, 1'b0, 32'h0, 4'd3, 32'd0, 4'd6);
        cdb_valid = 2'b11;
        cdb_tag   = {4'd3, 4'd3};
        cdb_value = {32'd99, 32'd9};
        step();
        idle();
        total++; if (iss_valid !== 1'b1) $display("FAIL bp_iss_valid got %b want 1", iss_valid); else passed++;
        total++; if (iss_vk !== 32'd9)   $display("FAIL bp_vk got %0d want 9", iss_vk); else passed++;
        total++; if (iss_vj !== 32'd1)   $display("FAIL bp_vj got %0d want 1", iss_vj); else passed++;
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;
    endtask

    task automatic test_age_order();
        set_disp(1'b0, 32'h0, 4'd4, 1'b1, 32'd0, 4'h0, 32'd0, 4'd10); step();
        set_disp(1'b1, 32'd20, 4'h0, 1'b1, 32'd0, 4'h0, 32'd0, 4'd11); step();
        set_disp(1'b1, 32'd30, 4'h0, 1'b1, 32'd0, 4'h0, 32'd0, 4'd12); step();
        disp_valid = 1'b0;
        total++; if (count !== 4'd3)     $display("FAIL age_count got %0d want 3", count); else passed++;
        total++; if (iss_dest !== 4'd11) $display("FAIL age_first got %0d want 11", iss_dest); else passed++;
        iss_ready = 1'b1;
        step();
        total++; if (iss_dest !== 4'd12) $display("FAIL age_second got %0d want 12", iss_dest); else passed++;
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd4}; cdb_value = {32'd0, 32'h44};
        step();
        cdb_valid = 2'b00;
        total++; if (iss_dest !== 4'd10) $display("FAIL age_third got %0d want 10", iss_dest); else passed++;
        total++; if (iss_vj !== 32'h44)  $display("FAIL age_third_vj got %h want 44", iss_vj); else passed++;
        step();
        total++; if (iss_valid !== 1'b0) $display("FAIL age_drained got %b want 0", iss_valid); else passed++;
        iss_ready = 1'b0;
        set_disp(1'b0, 32'h0, 4'd5, 1'b1, 32'd0, 4'h0, 32'd0, 4'd1); step();
        set_disp(1'b1, 32'd2, 4'h0, 1'b1, 32'd0, 4'h0, 32'd0, 4'd2); step();
        set_disp(1'b1, 32'd3, 4'h0, 1'b1, 32'd0, 4'h0, 32'd0, 4'd3); step();
        disp_valid = 1'b0;
        cdb_valid = 2'b10; cdb_tag = {4'd5, 4'd0}; cdb_value = {32'h55, 32'd0};
        step();
        cdb_valid = 2'b00;
        total++; if (iss_dest !== 4'd1) $display("FAIL age_woken_oldest got %0d want 1", iss_dest); else passed++;
        iss_ready = 1'b1;
        step();
        total++; if (iss_dest !== 4'd2) $display("FAIL age_next got %0d want 2", iss_dest); else passed++;
        step();
        total++; if (iss_dest !== 4'd3) $display("FAIL age_last got %0d want 3", iss_dest); else passed++;
        step();
        iss_ready = 1'b0;
        total++; if (count !== 4'd0) $display("FAIL age_end_count got %0d want 0", count); else passed++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            set_disp(1'b0, 32'h0, 4'd9, 1'b1, 32'd0, 4'h0, 32'd0, 4'(i));
            step();
        end
        total++; if (disp_ready !== 1'b0) $display("FAIL full_disp_ready got %b want 0", disp_ready); else passed++;
        total++; if (count !== 4'd8)      $display("FAIL full_count got %0d want 8", count); else passed++;
        set_disp(1'b1, 32'd1, 4'h0, 1'b1, 32'd0, 4'h0, 32'd0, 4'd15);
        step();
        disp_valid = 1'b0;
        total++; if (count !== 4'd8)      $display("FAIL full_ignored got %0d want 8", count); else passed++;
        total++; if (iss_valid !== 1'b0)  $display("FAIL full_iss_valid got %b want 0", iss_valid); else passed++;
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd9}; cdb_value = {32'd0, 32'd90};
        step();
        cdb_valid = 2'b00;
        iss_ready = 1'b1;
        step();
        total++; if (count !== 4'd7)      $display("FAIL full_after_issue got %0d want 7", count); else passed++;
        total++; if (iss_dest !== 4'd1)   $display("FAIL full_next_dest got %0d want 1", iss_dest); else passed++;
        set_disp(1'b1, 32'd7, 4'h0, 1'b1, 32'd0, 4'h0, 32'd0, 4'd14);
        step();
        idle();
        total++; if (count !== 4'd7)      $display("FAIL full_both_fire got %0d want 7", count); else passed++;
        total++; if (disp_ready !== 1'b1) $display("FAIL full_ready_again got %b want 1", disp_ready); else passed++;
        total++; if (iss_dest !== 4'd2)   $display("FAIL full_oldest got %0d want 2", iss_dest); else passed++;
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            set_disp(1'b1, 32'(i), 4'h0, 1'b1, 32'd0, 4'h0, 32'd0, 4'(i));
            step();
        end
        disp_valid = 1'b0;
        total++; if (count !== 4'd5) $display("FAIL fl_count5 got %0d want 5", count); else passed++;
        set_disp(1'b1, 32'd1, 4'h0, 1'b1, 32'd0, 4'h0, 32'd0, 4'd9);
        flush_in  = 1'b1;
        iss_ready = 1'b1;
        step();
        idle();
        total++; if (count !== 4'd0)      $display("FAIL fl_count got %0d want 0", count); else passed++;
        total++; if (iss_valid !== 1'b0)  $display("FAIL fl_iss_valid got %b want 0", iss_valid); else passed++;
        total++; if (disp_ready !== 1'b1) $display("FAIL fl_disp_ready got %b want 1", disp_ready); else passed++;
        step();
        total++; if (count !== 4'd0)      $display("FAIL fl_no_alloc got %0d want 0", count); else passed++;
    endtask

    task automatic test_freeze();
        rdy_in = 1'b0;
        set_disp(1'b1, 32'd6, 4'h0, 1'b1, 32'd0, 4'h0, 32'd0, 4'd6);
        step();
        total++; if (count !== 4'd0) $display("FAIL fz_no_disp got %0d want 0", count); else passed++;
        rdy_in = 1'b1;
        step();
        disp_valid = 1'b0;
        total++; if (count !== 4'd1) $display("FAIL fz_disp got %0d want 1", count); else passed++;
        rdy_in = 1'b0; iss_ready = 1'b1;
        step();
        total++; if (iss_valid !== 1'b1) $display("FAIL fz_hold_valid got %b want 1", iss_valid); else passed++;
        total++; if (count !== 4'd1)     $display("FAIL fz_hold_count got %0d want 1", count); else passed++;
        total++; if (iss_dest !== 4'd6)  $display("FAIL fz_hold_dest got %0d want 6", iss_dest); else passed++;
        rdy_in = 1'b1;
        step();
        iss_ready = 1'b0;
        total++; if (count !== 4'd0) $display("FAIL fz_release got %0d want 0", count); else passed++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            set_disp(1'b1, 32'h77, 4'h0, 1'b1, 32'h88, 4'h0, 32'h99, 4'(i + 3));
            step();
        end
        disp_valid = 1'b0;
        total++; if (count !== 4'd3) $display("FAIL ar_pre_count got %0d want 3", count); else passed++;
        #2;
        rst_in = 1'b1;
        #1;
        total++; if (count !== 4'd0)      $display("FAIL ar_count got %0d want 0", count); else passed++;
        total++; if (iss_valid !== 1'b0)  $display("FAIL ar_iss_valid got %b want 0", iss_valid); else passed++;
        total++; if (disp_ready !== 1'b1) $display("FAIL ar_disp_ready got %b want 1", disp_ready); else passed++;
        total++; if (iss_vj !== 32'h0)    $display("FAIL ar_vj got %h want 0", iss_vj); else passed++;
        total++; if (iss_dest !== 4'd0)   $display("FAIL ar_dest got %0d want 0", iss_dest); else passed++;
        step();
        rst_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_bypass();
        test_age_order();
        test_full();
        test_flush();
        test_freeze();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
